// File: rtl/pic_mem_pkg.sv
// Shared widths and default program image for the PIC-style memory subsystem.
// Used by both the program ROM and the data RAM.
package pic_mem_pkg;

    localparam int ROM_AW    = 11;
    localparam int ROM_DW    = 14;
    localparam int RAM_AW    = 7;
    localparam int RAM_DW    = 8;
    localparam int RAM_DEPTH = 1 << RAM_AW;

    // Built-in demo program; every address not listed reads as NOP (0)
    localparam logic [ROM_DW-1:0] PROG_W0 = 14'h3005; // MOVLW 05
    localparam logic [ROM_DW-1:0] PROG_W1 = 14'h3E03; // ADDLW 03
    localparam logic [ROM_DW-1:0] PROG_W2 = 14'h07A0; // ADDWF 20,f
    localparam logic [ROM_DW-1:0] PROG_W3 = 14'h0103; // CLRW
    localparam logic [ROM_DW-1:0] PROG_W4 = 14'h0720; // ADDWF 20,w
    localparam logic [ROM_DW-1:0] PROG_W5 = 14'h09A0; // COMF 20,f
    localparam logic [ROM_DW-1:0] PROG_W6 = 14'h03A0; // DECF 20,f
    localparam logic [ROM_DW-1:0] PROG_W7 = 14'h0520; // ANDWF 20,w
    localparam logic [ROM_DW-1:0] PROG_W8 = 14'h01A0; // CLRF 20
    localparam logic [ROM_DW-1:0] PROG_W9 = 14'h2800; // GOTO 0
    localparam logic [ROM_DW-1:0] PROG_NOP = 14'h0000;

endpackage

// File: rtl/dram_128x8.sv
// 128x8 file-register RAM: asynchronous read, synchronous write, synchronous clear.
// The read port sees the pre-edge contents, so a same-cycle read-modify-write is clean.
module dram_128x8
    import pic_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RAM_AW-1:0] addr,
    input  logic [RAM_DW-1:0] wdata,
    input  logic              we,
    output logic [RAM_DW-1:0] q
);

    logic [RAM_DW-1:0] mem_reg [RAM_DEPTH];

    // Clear has priority; a write presented alongside rst is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

    assign q = mem_reg[addr];

endmodule

// File: rtl/pic_mem_subsystem.sv
// Program ROM plus data RAM for the 14-bit PIC-style CPU.
// The ROM holds the built-in default program table; unlisted addresses read as NOP.
module pic_mem_subsystem
    import pic_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ROM_AW-1:0] rom_addr_in,
    output logic [ROM_DW-1:0] rom_data_out,
    input  logic [RAM_AW-1:0] ram_addr,
    input  logic [RAM_DW-1:0] ram_data,
    input  logic              ram_en,
    output logic [RAM_DW-1:0] ram_q
);

    always_comb begin
        rom_data_out = PROG_NOP;
        case (rom_addr_in)
            11'd0:   rom_data_out = PROG_W0;
            11'd1:   rom_data_out = PROG_W1;
            11'd2:   rom_data_out = PROG_W2;
            11'd3:   rom_data_out = PROG_W3;
            11'd4:   rom_data_out = PROG_W4;
            11'd5:   rom_data_out = PROG_W5;
            11'd6:   rom_data_out = PROG_W6;
            11'd7:   rom_data_out = PROG_W7;
            11'd8:   rom_data_out = PROG_W8;
            11'd9:   rom_data_out = PROG_W9;
            default: rom_data_out = PROG_NOP;
        endcase
    end

    dram_128x8 u_dram (
        .clk   (clk),
        .rst   (rst),
        .addr  (ram_addr),
        .wdata (ram_data),
        .we    (ram_en),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_pic_mem_subsystem.sv
// Directed self-checking bench for pic_mem_subsystem: ROM table sweep and RAM
// reset, write, read-modify-write, reset priority and address independence.
module tb_pic_mem_subsystem;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] rom_addr_in;
    logic [13:0] rom_data_out;
    logic [6:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        ram_en;
    logic [7:0]  ram_q;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pic_mem_subsystem dut (
        .clk          (clk),
        .rst          (rst),
        .rom_addr_in  (rom_addr_in),
        .rom_data_out (rom_data_out),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_en       (ram_en),
        .ram_q        (ram_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %-14s got %h", tag, got);
        end else begin
            $display("FAIL %-14s got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs move 1 time unit after the rising edge, well away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
        ram_addr = a;
        #1;
        check(tag, 32'(ram_q), 32'(exp));
    endtask

    logic [13:0] rom_exp [10];

    initial begin
        rom_exp = '{14'h3005, 14'h3E03, 14'h07A0, 14'h0103, 14'h0720,
                    14'h09A0, 14'h03A0, 14'h0520, 14'h01A0, 14'h2800};
        rst = 1'b1; rom_addr_in = '0; ram_addr = '0; ram_data = '0; ram_en = 1'b0;
        tick();
        rst = 1'b0;

        // ROM sweep, combinational only
        for (int i = 0; i < 10; i++) begin
            rom_addr_in = 11'(i);
            #1;
            check($sformatf("rom[%0d]", i), 32'(rom_data_out), 32'(rom_exp[i]));
        end
        rom_addr_in = 11'd10;
        #1;
        check("rom[10]", 32'(rom_data_out), 32'h0000);
        rom_addr_in = 11'd2047;
        #1;
        check("rom[2047]", 32'(rom_data_out), 32'h0000);

        // Reset clears written data
        read_check("post_rst_20", 7'h20, 8'h00);
        ram_addr = 7'h20; ram_data = 8'hAA; ram_en = 1'b1;
        tick();
        ram_en = 1'b0;
        read_check("wr_aa", 7'h20, 8'hAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_check("rst_clr_20", 7'h20, 8'h00);
        read_check("rst_clr_7f", 7'h7F, 8'h00);

        // Write then hold with ram_en low
        ram_addr = 7'h20; ram_data = 8'h5A; ram_en = 1'b1;
        tick();
        ram_en = 1'b0; ram_data = 8'hFF;
        read_check("wr_5a", 7'h20, 8'h5A);
        tick();
        tick();
        read_check("hold_5a", 7'h20, 8'h5A);

        // Read-modify-write in one cycle
        ram_addr = 7'h20;
        #1;
        ram_data = ~ram_q;
        ram_en = 1'b1;
        #1;
        check("rmw_pre", 32'(ram_q), 32'h5A);
        tick();
        ram_en = 1'b0;
        read_check("rmw_post", 7'h20, 8'hA5);

        // Reset wins over a simultaneous write
        ram_addr = 7'h10; ram_data = 8'h33; ram_en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; ram_en = 1'b0;
        read_check("rst_prio_10", 7'h10, 8'h00);
        read_check("rst_prio_20", 7'h20, 8'h00);

        // Address independence
        ram_addr = 7'h00; ram_data = 8'h11; ram_en = 1'b1;
        tick();
        ram_addr = 7'h7F; ram_data = 8'h22;
        tick();
        ram_en = 1'b0;
        read_check("ind_00", 7'h00, 8'h11);
        read_check("ind_7f", 7'h7F, 8'h22);
        read_check("ind_40", 7'h40, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
